// File: rtl/lfsr_stream_gen_if.sv
// Output stream of the LFSR generator: one word of PARALLEL_SAMPLES
// consecutive LFSR states with a valid/ready handshake.
interface lfsr_stream_gen_if #(
  parameter int WIDTH            = 16,
  parameter int PARALLEL_SAMPLES = 4
);
  logic [PARALLEL_SAMPLES-1:0][WIDTH-1:0] data_out;
  logic                                   data_valid;
  logic                                   data_ready;

  modport master (output data_out, output data_valid, input data_ready);
  modport slave  (input data_out, input data_valid, output data_ready);
endinterface

// File: rtl/lfsr_stream_gen.sv
// Parallel Galois LFSR source: each output word carries PARALLEL_SAMPLES
// consecutive states; successive words continue one contiguous sequence.
module lfsr_stream_gen #(
  parameter int               WIDTH            = 16,
  parameter int               PARALLEL_SAMPLES = 4,
  parameter logic [WIDTH-1:0] POLY             = 16'hb400,
  parameter logic [WIDTH-1:0] SEED             = 16'hace1,
  parameter int               COUNT_WIDTH      = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       seed_in,
  input  logic                   seed_valid,
  output logic                   seed_ready,
  output logic                   seed_zero_err,
  input  logic                   start,
  input  logic                   stop,
  input  logic [COUNT_WIDTH-1:0] burst_len,
  output logic                   busy,
  output logic                   done,
  lfsr_stream_gen_if.master      stream
);

  typedef logic [PARALLEL_SAMPLES-1:0][WIDTH-1:0] lanes_t;
  typedef enum logic {S_IDLE, S_RUN} state_t;

  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] s);
    return ({WIDTH{s[0]}} & POLY) ^ (s >> 1);
  endfunction

  // Lane i = step^i(seed), so one word holds consecutive states.
  function automatic lanes_t init_lanes(input logic [WIDTH-1:0] seed);
    lanes_t l;
    l[0] = seed;
    for (int i = 1; i < PARALLEL_SAMPLES; i++) begin
      l[i] = step(l[i-1]);
    end
    return l;
  endfunction

  state_t                 state;
  lanes_t                 lanes;
  lanes_t                 adv_lanes;
  logic [COUNT_WIDTH-1:0] count;
  logic [COUNT_WIDTH-1:0] burst_len_q;
  logic                   stop_pend;
  logic                   data_valid_q;
  logic                   seed_is_zero;
  logic                   xfer;
  logic                   last_xfer;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    adv_lanes = lanes;
    for (int i = 0; i < PARALLEL_SAMPLES; i++) begin
      for (int k = 0; k < PARALLEL_SAMPLES; k++) begin
        adv_lanes[i] = step(adv_lanes[i]);
      end
    end
  end

  assign seed_is_zero = (seed_in == '0);
  assign seed_ready   = (state == S_IDLE);
  assign xfer         = (state == S_RUN) && data_valid_q && stream.data_ready;
  assign last_xfer    = xfer &&
                        (((burst_len_q != '0) && (count == burst_len_q - COUNT_WIDTH'(1)))
                         || stop_pend || stop);

  assign stream.data_out   = lanes;
  assign stream.data_valid = data_valid_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      lanes         <= init_lanes(SEED);
      count         <= '0;
      burst_len_q   <= '0;
      stop_pend     <= 1'b0;
      data_valid_q  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      seed_zero_err <= 1'b0;
    end else begin
      done          <= 1'b0;
      seed_zero_err <= 1'b0;
      case (state)
        S_IDLE: begin
          // Seed load takes effect before a same-cycle start.
          if (seed_valid) begin
            lanes         <= init_lanes(seed_is_zero ? SEED : seed_in);
            seed_zero_err <= seed_is_zero;
          end
          if (start) begin
            state        <= S_RUN;
            burst_len_q  <= burst_len;
            count        <= '0;
            stop_pend    <= 1'b0;
            data_valid_q <= 1'b1;
            busy         <= 1'b1;
          end
        end
        S_RUN: begin
          if (xfer) begin
            lanes <= adv_lanes;
            count <= count + COUNT_WIDTH'(1);
            if (last_xfer) begin
              state        <= S_IDLE;
              data_valid_q <= 1'b0;
              busy         <= 1'b0;
              done         <= 1'b1;
            end
          end else if (stop) begin
            stop_pend <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/lfsr_stream_gen.md
Name: lfsr_stream_gen

Overview:
- Parametrised Galois LFSR pseudo-random source. Produces PARALLEL_SAMPLES consecutive LFSR states per output word on a valid/ready stream.
- Used as the test-pattern and noise source feeding the DDS/DAC sample pipeline.
- Generalises the fixed 16-bit parallel LFSR with:
  - configurable width, polynomial and seed;
  - run-time seed load;
  - output backpressure;
  - burst-length and free-run modes;
  - all-zero lockup guard.

Parameters:
- WIDTH, 16: LFSR state width in bits, 4..64.
- PARALLEL_SAMPLES, 4: LFSR states emitted per word, 1..16.
- POLY, 16'hb400: Galois feedback mask, WIDTH bits. Must be nonzero with MSB set.
- SEED, 16'hace1: default seed, WIDTH bits, nonzero. Also the substitute for a rejected zero seed.
- COUNT_WIDTH, 16: width of the burst length and word counter.

Ports:
- clk, input, 1: clock.
- reset, input, 1: asynchronous, active-low reset.
- seed_in, input, WIDTH: run-time seed.
- seed_valid, input, 1: seed_in valid.
- seed_ready, output, 1: seed accepted when seed_valid && seed_ready.
- seed_zero_err, output, 1: one-cycle pulse when an all-zero seed is rejected.
- start, input, 1: begin generation (level, sampled in IDLE).
- stop, input, 1: request end of free-run or burst.
- burst_len, input, COUNT_WIDTH: words per burst. 0 = free-run. Sampled on start.
- data_out, output, [PARALLEL_SAMPLES-1:0][WIDTH-1:0]: lane i = state i of the sequence.
- data_valid, output, 1: data_out valid.
- data_ready, input, 1: downstream ready.
- busy, output, 1: high in RUN.
- done, output, 1: one-cycle pulse on return to IDLE.

Behaviour:
- Step function: step(s) = ({WIDTH{s[0]}} & POLY) ^ (s >> 1). The block holds one WIDTH register per lane.
- Reset (reset low, asynchronous):
  - state = IDLE;
  - lane i = step^i(SEED);
  - data_valid = 0, busy = 0, done = 0, seed_zero_err = 0;
  - word counter = 0, stop_pend = 0;
  - seed_ready = 1 (it is combinational: 1 iff state == IDLE).
- Reset asserted mid-burst clears everything immediately. No done pulse.
- Seed load (IDLE, seed_valid && seed_ready):
  - next cycle lane i = step^i(seed_in);
  - if seed_in == 0, SEED is used instead and seed_zero_err pulses for 1 cycle.
- If seed load and start occur in the same cycle, the seed is loaded first. RUN then starts from the new seed.
- IDLE -> RUN on start:
  - latch burst_len;
  - counter = 0, stop_pend = 0;
  - data_valid = 1 and busy = 1 from the next cycle. Latency start -> first valid = 1 cycle.
- RUN, data_valid && data_ready (transfer):
  - every lane advances by step^PARALLEL_SAMPLES, so the lanes of successive words form one contiguous sequence;
  - counter increments.
- No transfer: lanes and data_valid hold. data_out is stable under backpressure.
- Last transfer is the transfer where either:
  - burst_len != 0 and counter == burst_len-1, or
  - stop_pend is set, or stop is high in the same cycle.
- On the last transfer:
  - next cycle state = IDLE, data_valid = 0, busy = 0, done = 1 for one cycle;
  - lanes hold the advanced state, so the next start continues the sequence.
- stop in RUN without a transfer sets stop_pend. data_valid never drops before a transfer.
- stop in IDLE is ignored. start in RUN is ignored.
- Counter width: burst_len up to 2^COUNT_WIDTH-1. The counter does not wrap in burst mode. In free-run mode the counter wraps silently and is not otherwise used.
- Lane recurrences are computed combinationally from registered state. No extra pipeline latency.

Test Plan:
- Lane initialisation: defaults (WIDTH 16, POLY b400, SEED ace1), reset, start, burst_len 0, data_ready 1.
  - First word lanes 0..3 = ace1, e270, 7138, 389c.
  - Second word lane 0 = 1c4e, lane 1 = 0e27.
- Burst with backpressure: burst_len 3, data_ready toggled 1/0.
  - Exactly 3 transfers.
  - data_out constant while ready is low.
  - done pulses once, 1 cycle after the 3rd transfer; data_valid then 0.
- Zero-seed guard: seed_in 0000 with seed_valid in IDLE.
  - seed_zero_err pulses 1 cycle.
  - Next run's first word = ace1, e270, 7138, 389c.
- Seed load: seed_in 0001 loaded, then start.
  - Lane 0 = 0001, lane 1 = b400.
  - seed_ready is 0 throughout RUN.
- Stop handling: free-run, stop pulsed while data_ready = 0, then ready raised.
  - Exactly one further transfer, then done.
  - A subsequent start continues the sequence from the next state.
- Asynchronous reset mid-burst: reset low mid-burst.
  - data_valid, busy and done go 0 immediately.
  - Lanes return to step^i(SEED).
  - No done pulse.
